// File: rtl/mul_pkg.sv
// Shared types for the pipelined multiplier: opcode enum, stage packet and chunk-width formula.
package mul_pkg;

  localparam int MUL_XLEN    = 32;
  localparam int MUL_STAGES  = 4;
  localparam int MUL_PRF_LEN = 6;
  localparam int MUL_ROB_LEN = 5;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } MUL_FUNC;

  typedef struct packed {
    logic                      valid;
    MUL_FUNC                   func;
    logic [MUL_PRF_LEN-1:0]    prf;
    logic [MUL_ROB_LEN-1:0]    rob;
    logic [2*MUL_XLEN-1:0]     p;
    logic [2*MUL_XLEN-1:0]     m;
    logic [2*MUL_XLEN-1:0]     r;
  } MUL_STAGE_PACKET;

  // Multiplier bits retired per stage; stages must divide 2*xlen.
  function automatic int cw_of(input int xlen, input int stages);
    return (2 * xlen) / stages;
  endfunction

endpackage

// File: rtl/pipe_mul_step.sv
// One radix-2^CW shift-add step: fold the low CW multiplier bits into the partial product.
module pipe_mul_step #(
  parameter int W  = 64,
  parameter int CW = 16
) (
  input  logic [W-1:0] p_i,
  input  logic [W-1:0] m_i,
  input  logic [W-1:0] r_i,
  output logic [W-1:0] p_o,
  output logic [W-1:0] m_o,
  output logic [W-1:0] r_o
);

  assign p_o = p_i + (W'(r_i[CW-1:0]) * m_i);
  assign m_o = m_i << CW;
  assign r_o = r_i >> CW;

endmodule

// File: rtl/pipe_mul_unit.sv
// Pipelined MUL/MULH/MULHSU/MULHU unit with collapsing stage valids, CDB backpressure and squash.
module pipe_mul_unit
  import mul_pkg::*;
#(
  parameter int XLEN    = MUL_XLEN,
  parameter int STAGES  = MUL_STAGES,
  parameter int PRF_LEN = MUL_PRF_LEN,
  parameter int ROB_LEN = MUL_ROB_LEN
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  MUL_FUNC            in_func,
  input  logic [XLEN-1:0]    in_opa,
  input  logic [XLEN-1:0]    in_opb,
  input  logic [PRF_LEN-1:0] in_prf,
  input  logic [ROB_LEN-1:0] in_rob,
  input  logic               squash,
  output logic               out_valid,
  output logic [XLEN-1:0]    out_value,
  output logic [PRF_LEN-1:0] out_prf,
  output logic [ROB_LEN-1:0] out_rob,
  input  logic               cdb_grant,
  output logic               busy
);

  localparam int W  = 2 * XLEN;
  localparam int CW = cw_of(XLEN, STAGES);

  MUL_STAGE_PACKET stg_q [1:STAGES];
  MUL_STAGE_PACKET stg_d [1:STAGES];

  logic [W-1:0] p_in [STAGES];
  logic [W-1:0] m_in [STAGES];
  logic [W-1:0] r_in [STAGES];
  logic [W-1:0] p_nx [STAGES];
  logic [W-1:0] m_nx [STAGES];
  logic [W-1:0] r_nx [STAGES];

  logic [STAGES:1] adv;
  logic            sx_a, sx_b;

  assign sx_a = (in_func != MULHU);
  assign sx_b = (in_func == MUL) || (in_func == MULH);

  assign p_in[0] = '0;
  assign m_in[0] = {{XLEN{sx_a & in_opa[XLEN-1]}}, in_opa};
  assign r_in[0] = {{XLEN{sx_b & in_opb[XLEN-1]}}, in_opb};

  for (genvar s = 1; s < STAGES; s++) begin : g_feed
    assign p_in[s] = stg_q[s].p;
    assign m_in[s] = stg_q[s].m;
    assign r_in[s] = stg_q[s].r;
  end

  // Step s feeds stage s+1; stage 1 already holds one step applied to the operands.
  for (genvar s = 0; s < STAGES; s++) begin : g_step
    pipe_mul_step #(.W(W), .CW(CW)) u_step (
      .p_i (p_in[s]),
      .m_i (m_in[s]),
      .r_i (r_in[s]),
      .p_o (p_nx[s]),
      .m_o (m_nx[s]),
      .r_o (r_nx[s])
    );
  end

  always_comb begin
    stg_d[1].valid = in_valid;
    stg_d[1].func  = in_func;
    stg_d[1].prf   = in_prf;
    stg_d[1].rob   = in_rob;
    stg_d[1].p     = p_nx[0];
    stg_d[1].m     = m_nx[0];
    stg_d[1].r     = r_nx[0];
    for (int s = 2; s <= STAGES; s++) begin
      stg_d[s].valid = stg_q[s-1].valid;
      stg_d[s].func  = stg_q[s-1].func;
      stg_d[s].prf   = stg_q[s-1].prf;
      stg_d[s].rob   = stg_q[s-1].rob;
      stg_d[s].p     = p_nx[s-1];
      stg_d[s].m     = m_nx[s-1];
      stg_d[s].r     = r_nx[s-1];
    end
  end

  // A stage moves when it is empty or everything ahead of it moves.
  always_comb begin
    adv         = '0;
    adv[STAGES] = !stg_q[STAGES].valid | cdb_grant;
    for (int s = STAGES - 1; s >= 1; s--)
      adv[s] = !stg_q[s].valid | adv[s+1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 1; s <= STAGES; s++) stg_q[s].valid <= 1'b0;
    end else begin
      for (int s = 1; s <= STAGES; s++) begin
        if (adv[s]) stg_q[s] <= stg_d[s];
        if (squash) stg_q[s].valid <= 1'b0;
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 1; s <= STAGES; s++) busy = busy | stg_q[s].valid;
  end

  assign in_ready  = adv[1];
  assign out_valid = stg_q[STAGES].valid;
  assign out_prf   = stg_q[STAGES].prf;
  assign out_rob   = stg_q[STAGES].rob;
  assign out_value = (stg_q[STAGES].func == MUL) ? stg_q[STAGES].p[XLEN-1:0]
                                                 : stg_q[STAGES].p[W-1:XLEN];

  logic unused_tail;
  assign unused_tail = ^{stg_q[STAGES].m, stg_q[STAGES].r};

endmodule

// File: tb/tb_pipe_mul_unit.sv
// Self-checking bench: vector table, directed corner sequences and randomized traffic vs a queue model.
module tb_pipe_mul_unit;
  import mul_pkg::*;

  localparam int S = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  MUL_FUNC     in_func = MUL;
  logic [31:0] in_opa = '0, in_opb = '0;
  logic [5:0]  in_prf = '0;
  logic [4:0]  in_rob = '0;
  logic        squash = 1'b0;
  logic        out_valid;
  logic [31:0] out_value;
  logic [5:0]  out_prf;
  logic [4:0]  out_rob;
  logic        cdb_grant = 1'b0;
  logic        busy;

  always #5 clock = ~clock;

  pipe_mul_unit dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_func   (in_func),
    .in_opa    (in_opa),
    .in_opb    (in_opb),
    .in_prf    (in_prf),
    .in_rob    (in_rob),
    .squash    (squash),
    .out_valid (out_valid),
    .out_value (out_value),
    .out_prf   (out_prf),
    .out_rob   (out_rob),
    .cdb_grant (cdb_grant),
    .busy      (busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: in-flight ops in issue order; elig = first edge count at which the op may show on the output.
  typedef struct {
    logic [31:0] val;
    logic [5:0]  prf;
    logic [4:0]  rob;
    int          elig;
  } exp_t;
  exp_t q[$];

  typedef struct {
    MUL_FUNC     f;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  prf;
    logic [4:0]  rob;
    logic [31:0] exp;
  } vec_t;
  vec_t tv[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_mul(input MUL_FUNC f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, prod;
    ea   = (f == MULHU) ? {32'd0, a} : {{32{a[31]}}, a};
    eb   = (f == MUL || f == MULH) ? {{32{b[31]}}, b} : {32'd0, b};
    prod = ea * eb;
    return (f == MUL) ? prod[31:0] : prod[63:32];
  endfunction

  // Inputs for this cycle are already driven; check outputs, update model, advance one edge.
  task automatic tick();
    logic exp_rdy, exp_ov;
    exp_t e;
    #1;
    exp_rdy = (q.size() < S) || cdb_grant;
    exp_ov  = (q.size() > 0) && (cyc >= q[0].elig);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    chk("busy", {31'd0, busy}, {31'd0, (q.size() != 0)});
    if (exp_ov && out_valid) begin
      chk("out_value", out_value, q[0].val);
      chk("out_prf", {26'd0, out_prf}, {26'd0, q[0].prf});
      chk("out_rob", {27'd0, out_rob}, {27'd0, q[0].rob});
    end
    if (squash) q.delete();
    else begin
      if (exp_ov && cdb_grant) begin
        void'(q.pop_front());
        if (q.size() > 0 && q[0].elig < cyc + 1) q[0].elig = cyc + 1;
      end
      if (in_valid && exp_rdy) begin
        e.val  = ref_mul(in_func, in_opa, in_opb);
        e.prf  = in_prf;
        e.rob  = in_rob;
        e.elig = cyc + S;
        q.push_back(e);
      end
    end
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic drive_op(input MUL_FUNC f, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] p, input logic [4:0] r);
    in_valid = 1'b1;
    in_func  = f;
    in_opa   = a;
    in_opb   = b;
    in_prf   = p;
    in_rob   = r;
  endtask

  task automatic drive_rand();
    drive_op(MUL_FUNC'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
             ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
             6'($urandom), 5'($urandom));
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    squash    = 1'b0;
    cdb_grant = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 30) begin
      tick();
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int lat, first, last, nvalid;
    logic [31:0] held;

    tv[0] = '{MUL,    32'd7,         32'hFFFF_FFFD, 6'd5,  5'd2,  32'hFFFF_FFEB};
    tv[1] = '{MULH,   32'h8000_0000, 32'h8000_0000, 6'd1,  5'd1,  32'h4000_0000};
    tv[2] = '{MULHU,  32'h8000_0000, 32'h8000_0000, 6'd2,  5'd3,  32'h4000_0000};
    tv[3] = '{MULHSU, 32'h8000_0000, 32'h8000_0000, 6'd3,  5'd4,  32'hC000_0000};
    tv[4] = '{MUL,    32'h8000_0000, 32'h8000_0000, 6'd4,  5'd5,  32'h0000_0000};
    tv[5] = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd63, 5'd31, 32'hFFFF_FFFE};
    tv[6] = '{MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd9,  5'd7,  32'hFFFF_FFFF};
    tv[7] = '{MUL,    32'h1234_5678, 32'h0000_0010, 6'd17, 5'd9,  32'h2345_6780};

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // table: single ops, grant held high, latency STAGES cycles
    cdb_grant = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_op(tv[i].f, tv[i].a, tv[i].b, tv[i].prf, tv[i].rob);
      tick();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 12) begin
        tick();
        lat++;
      end
      chk("vec_latency", 32'(lat), 32'(S));
      chk("vec_value", out_value, tv[i].exp);
      chk("vec_prf", {26'd0, out_prf}, {26'd0, tv[i].prf});
      chk("vec_rob", {27'd0, out_rob}, {27'd0, tv[i].rob});
      tick();
    end

    // throughput: 8 back-to-back with grant high
    first = -1; last = -1; nvalid = 0;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) drive_rand();
      else in_valid = 1'b0;
      tick();
      if (out_valid) begin
        nvalid++;
        if (first < 0) first = cyc;
        last = cyc;
      end
    end
    chk("tput_count", 32'(nvalid), 32'd8);
    chk("tput_contig", 32'(last - first + 1), 32'd8);

    // backpressure: fill with grant low
    cdb_grant = 1'b0;
    for (int i = 0; i < S; i++) begin
      drive_rand();
      tick();
    end
    drive_rand();
    #1;
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
    held = out_value;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stable", out_value, held);
    end
    cdb_grant = 1'b1;
    drive_rand();
    #1;
    chk("bp_grant_ready", {31'd0, in_ready}, 32'd1);
    tick();
    cdb_grant = 1'b0;
    drive_rand();
    #1;
    chk("bp_refull_ready", {31'd0, in_ready}, 32'd0);
    tick();
    drain();

    // bubble collapse: issue, gap, issue, stall
    cdb_grant = 1'b0;
    drive_rand(); tick();
    in_valid = 1'b0; tick();
    drive_rand(); tick();
    in_valid = 1'b0;
    repeat (6) tick();
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    chk("bubble_adjacent", {31'd0, out_valid}, 32'd1);
    tick();
    drain();

    // squash with 3 in flight plus a same-cycle issue
    cdb_grant = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      tick();
    end
    drive_rand();
    squash = 1'b1;
    tick();
    squash   = 1'b0;
    in_valid = 1'b0;
    chk("squash_busy", {31'd0, busy}, 32'd0);
    chk("squash_out_valid", {31'd0, out_valid}, 32'd0);
    repeat (8) tick();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 7) drive_rand();
      else in_valid = 1'b0;
      cdb_grant = ($urandom_range(0, 9) < 6);
      squash    = ($urandom_range(0, 39) == 0);
      tick();
    end
    drain();

    // async reset between edges
    cdb_grant = 1'b0;
    for (int i = 0; i < S; i++) begin
      drive_rand();
      tick();
    end
    in_valid = 1'b0;
    #1;
    chk("prerst_out_valid", {31'd0, out_valid}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    q.delete();
    @(posedge clock);
    cyc++;
    #1;
    reset     = 1'b1;
    cdb_grant = 1'b1;
    repeat (8) tick();

    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
